// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU control codes, funct codes, ALUOp classes and the
//            mul/div engine state type for the MIPS-32 ALU control block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// ============================================================================
// Module   : alu_ctrl_decode
// Purpose  : Combinational ALUOp/Funct decode into the 4-bit ALU control code
//            plus HI/LO-class instruction flags for the mul/div engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [3:0] ALUControl,
  output logic       illegal_funct,
  output logic       md_class,
  output logic       md_start,
  output logic       md_is_mul,
  output logic       md_signed,
  output logic       op_mfhi,
  output logic       op_mflo,
  output logic       op_mthi,
  output logic       op_mtlo
);

  always_comb begin
    ALUControl    = ALU_ADD;
    illegal_funct = 1'b0;
    md_class      = 1'b0;
    md_start      = 1'b0;
    md_is_mul     = 1'b0;
    md_signed     = 1'b0;
    op_mfhi       = 1'b0;
    op_mflo       = 1'b0;
    op_mthi       = 1'b0;
    op_mtlo       = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_OR:  ALUControl = ALU_OR;
      default: begin
        case (Funct)
          FUNCT_ADD, FUNCT_ADDU: ALUControl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ALUControl = ALU_SUB;
          FUNCT_AND:             ALUControl = ALU_AND;
          FUNCT_OR:              ALUControl = ALU_OR;
          FUNCT_XOR:             ALUControl = ALU_XOR;
          FUNCT_NOR:             ALUControl = ALU_NOR;
          FUNCT_SLT:             ALUControl = ALU_SLT;
          FUNCT_SLTU:            ALUControl = ALU_SLTU;
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            md_class  = 1'b1;
            md_start  = 1'b1;
            md_is_mul = (Funct == FUNCT_MULT) || (Funct == FUNCT_MULTU);
            md_signed = (Funct == FUNCT_MULT) || (Funct == FUNCT_DIV);
          end
          FUNCT_MFHI: begin md_class = 1'b1; op_mfhi = 1'b1; end
          FUNCT_MFLO: begin md_class = 1'b1; op_mflo = 1'b1; end
          FUNCT_MTHI: begin md_class = 1'b1; op_mthi = 1'b1; end
          FUNCT_MTLO: begin md_class = 1'b1; op_mtlo = 1'b1; end
          default:    illegal_funct = 1'b1;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_decoder_muldiv.sv
// ============================================================================
// Module   : alu_decoder_muldiv
// Purpose  : MIPS-32 ALU control decode with an iterative radix-2 mul/div
//            engine, HI/LO registers and HI/LO hazard stall.
//            Optional: MULDIV_EARLY_TERM_EN ends a multiply once the
//            remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       ALUControl,
  output logic             illegal_funct,
  output logic             hilo_rd,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             stall,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic w_md_class, w_md_start, w_md_mul, w_md_signed;
  logic w_mfhi, w_mflo, w_mthi, w_mtlo;

  alu_ctrl_decode u_decode (
    .ALUOp         (ALUOp),
    .Funct         (Funct),
    .ALUControl    (ALUControl),
    .illegal_funct (illegal_funct),
    .md_class      (w_md_class),
    .md_start      (w_md_start),
    .md_is_mul     (w_md_mul),
    .md_signed     (w_md_signed),
    .op_mfhi       (w_mfhi),
    .op_mflo       (w_mflo),
    .op_mthi       (w_mthi),
    .op_mtlo       (w_mtlo)
  );

  md_state_t          r_state, w_next;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_acc;    // product, or {remainder, quotient} when dividing
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_opb;    // shifting multiplier, or static divisor
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_is_mul, r_sign_a, r_sign_b, r_bzero, r_busy, r_done;

  logic               w_idle, w_accept, w_wr_hi, w_wr_lo;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_prod_next, w_prod_fix;
  logic [WIDTH:0]     w_shift, w_diff;
  logic [WIDTH-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = instr_valid & w_md_start & w_idle;
  assign w_wr_hi  = instr_valid & w_mthi & w_idle;
  assign w_wr_lo  = instr_valid & w_mtlo & w_idle;

  assign stall      = instr_valid & w_md_class & (r_busy | ~w_idle);
  assign hilo_rd    = instr_valid & (w_mfhi | w_mflo);
  assign hilo_rdata = w_mfhi ? r_hi : r_lo;
  assign busy       = r_busy;
  assign done       = r_done;

  assign w_neg_a = w_md_signed & src_a[WIDTH-1];
  assign w_neg_b = w_md_signed & src_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -src_a : src_a;
  assign w_mag_b = w_neg_b ? -src_b : src_b;

  assign w_prod_next = r_acc + (r_opb[0] ? r_mcand : '0);
  // Remainder stays below the divisor, so one extra bit covers the shift.
  assign w_shift     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff      = w_shift - {1'b0, r_opb};

  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
  assign w_rem_fix  = r_sign_a ? -w_rem : w_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = ITER;
      ITER: begin
        if (r_count == C_LAST) w_next = FIXUP;
`ifdef MULDIV_EARLY_TERM_EN
        else if (r_is_mul && (r_opb[WIDTH-1:1] == '0)) w_next = FIXUP;
`endif
      end
      FIXUP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_mul <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_bzero  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_mul <= w_md_mul;
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_bzero  <= (src_b == '0);
            r_acc    <= w_md_mul ? '0 : {{WIDTH{1'b0}}, w_mag_a};
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_opb    <= w_mag_b;
            r_count  <= '0;
            r_busy   <= 1'b1;
          end
          if (w_wr_hi) r_hi <= src_a;
          if (w_wr_lo) r_lo <= src_a;
        end
        ITER: begin
          r_count <= r_count + CNT_W'(1);
          if (r_is_mul) begin
            r_acc   <= w_prod_next;
            r_mcand <= r_mcand << 1;
            r_opb   <= r_opb >> 1;
          end else if (!w_diff[WIDTH]) begin
            r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
          end
        end
        FIXUP: begin
          if (r_is_mul) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else begin
            r_lo <= r_bzero ? '1 : w_quo_fix;
            r_hi <= w_rem_fix;
          end
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_decoder_muldiv.sv
// ============================================================================
// Module   : tb_alu_decoder_muldiv
// Purpose  : Directed self-checking bench for alu_decoder_muldiv.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_decoder_muldiv;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk, rst, instr_valid;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [31:0] src_a, src_b;
  logic [3:0]  ALUControl;
  logic        illegal_funct, hilo_rd, stall, busy, done;
  logic [31:0] hilo_rdata;

  int checks = 0;
  int errors = 0;

  alu_decoder_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .ALUOp(ALUOp),
    .Funct(Funct), .src_a(src_a), .src_b(src_b), .ALUControl(ALUControl),
    .illegal_funct(illegal_funct), .hilo_rd(hilo_rd), .hilo_rdata(hilo_rdata),
    .stall(stall), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] ctrl;
    logic       ill;
  } dec_vec_t;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } md_vec_t;

  dec_vec_t dec_tab[19];
  md_vec_t  md_tab[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
    int n;
    logic [31:0] mag;
    n = 32;
    mag = b;
`ifdef MULDIV_EARLY_TERM_EN
    if (f == F_MULT || f == F_MULTU) begin
      if (f == F_MULT && b[31]) mag = -b;
      n = 1;
      for (int i = 1; i < 32; i++) if (mag[i]) n = i + 1;
    end
`endif
    return n + 1;
  endfunction

  task automatic read_hilo(input logic [5:0] f, output logic [31:0] v);
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = f;
    #1;
    v = hilo_rdata;
  endtask

  task automatic do_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int lat, bcnt;
    logic got;
    logic [31:0] v;
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = f; src_a = a; src_b = b;
    step();
    instr_valid = 1'b0;
    lat = 0; bcnt = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (busy) bcnt++;
      step();
      lat++;
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat(f, b)));
    check("busy_cycles", 64'(bcnt), 64'(exp_lat(f, b)));
    check("busy_low_at_done", 64'(busy), 64'd0);
    read_hilo(F_MFLO, v);
    check("lo", 64'(v), 64'(exp_lo));
    check("stall_at_done", 64'(stall), 64'd0);
    read_hilo(F_MFHI, v);
    check("hi", 64'(v), 64'(exp_hi));
    instr_valid = 1'b0;
    step();
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic        bad;
    int          lat;

    dec_tab[0]  = '{2'b00, 6'b000000, 4'b0010, 1'b0};
    dec_tab[1]  = '{2'b01, 6'b100111, 4'b0110, 1'b0};
    dec_tab[2]  = '{2'b11, 6'b111111, 4'b0001, 1'b0};
    dec_tab[3]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    dec_tab[4]  = '{2'b10, 6'b100001, 4'b0010, 1'b0};
    dec_tab[5]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    dec_tab[6]  = '{2'b10, 6'b100011, 4'b0110, 1'b0};
    dec_tab[7]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    dec_tab[8]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    dec_tab[9]  = '{2'b10, 6'b100110, 4'b0011, 1'b0};
    dec_tab[10] = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    dec_tab[11] = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    dec_tab[12] = '{2'b10, 6'b101011, 4'b1000, 1'b0};
    dec_tab[13] = '{2'b10, 6'b011011, 4'b0010, 1'b0};
    dec_tab[14] = '{2'b10, 6'b010011, 4'b0010, 1'b0};
    dec_tab[15] = '{2'b10, 6'b111111, 4'b0010, 1'b1};
    dec_tab[16] = '{2'b10, 6'b000000, 4'b0010, 1'b1};
    dec_tab[17] = '{2'b10, 6'b101100, 4'b0010, 1'b1};
    dec_tab[18] = '{2'b10, 6'b010100, 4'b0010, 1'b1};

    md_tab[0]  = '{F_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF};
    md_tab[1]  = '{F_DIVU,  32'd100,      32'd7,        32'd14,       32'd2};
    md_tab[2]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    md_tab[3]  = '{F_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 32'd5};
    md_tab[4]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    md_tab[5]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    md_tab[6]  = '{F_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
    md_tab[7]  = '{F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9};
    md_tab[8]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    md_tab[9]  = '{F_MULTU, 32'h12345678, 32'd1,        32'h12345678, 32'd0};
    md_tab[10] = '{F_MULTU, 32'h12345678, 32'd0,        32'd0,        32'd0};

    rst = 1'b1; instr_valid = 1'b0; ALUOp = 2'b00; Funct = 6'd0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    read_hilo(F_MFHI, v);
    check("reset_hi", 64'(v), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_hilo_rd", 64'(hilo_rd), 64'd1);
    read_hilo(F_MFLO, v);
    check("reset_lo", 64'(v), 64'd0);
    instr_valid = 1'b0;

    for (int i = 0; i < 19; i++) begin
      ALUOp = dec_tab[i].aluop; Funct = dec_tab[i].funct;
      #1;
      check($sformatf("dec_ctrl[%0d]", i), 64'(ALUControl), 64'(dec_tab[i].ctrl));
      check($sformatf("dec_illegal[%0d]", i), 64'(illegal_funct), 64'(dec_tab[i].ill));
    end

    for (int i = 0; i < 11; i++)
      do_muldiv(md_tab[i].funct, md_tab[i].a, md_tab[i].b, md_tab[i].lo, md_tab[i].hi);

    // MTHI/MTLO write at the next edge without a done pulse
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = F_MTHI; src_a = 32'hCAFEF00D;
    step();
    Funct = F_MTLO; src_a = 32'h0BADBEEF;
    step();
    instr_valid = 1'b0;
    check("mt_no_done", 64'(done), 64'd0);
    read_hilo(F_MFHI, v);
    check("mthi", 64'(v), 64'hCAFEF00D);
    read_hilo(F_MFLO, v);
    check("mtlo", 64'(v), 64'h0BADBEEF);
    instr_valid = 1'b0;

    // Hazard: MULTU 3x4, a rejected MULT, then MFLO stalls until done
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = F_MULTU; src_a = 32'd3; src_b = 32'd4;
    step();
    Funct = F_MULT; src_a = 32'd5; src_b = 32'd6;
    #1;
    check("stall_second_mult", 64'(stall), 64'd1);
    step();
    Funct = F_MFLO;
    bad = 1'b0; lat = 1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!stall) bad = 1'b1;
      step();
      lat++;
    end
    check("stall_while_busy", 64'(bad), 64'd0);
    check("hazard_done", 64'(done), 64'd1);
    check("hazard_latency", 64'(lat), 64'(exp_lat(F_MULTU, 32'd4)));
    #1;
    check("hazard_stall_done", 64'(stall), 64'd0);
    check("hazard_rdata", 64'(hilo_rdata), 64'd12);
    instr_valid = 1'b0;
    step();
    check("second_mult_rejected", 64'(busy), 64'd0);

    // Asynchronous reset at iteration 10 of a DIV
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = F_DIV; src_a = 32'd100; src_b = 32'd7;
    step();
    instr_valid = 1'b0;
    repeat (10) step();
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    read_hilo(F_MFHI, v);
    check("rst_hi", 64'(v), 64'd0);
    read_hilo(F_MFLO, v);
    check("rst_lo", 64'(v), 64'd0);
    instr_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) bad = 1'b1;
    end
    check("rst_no_done", 64'(bad), 64'd0);
    do_muldiv(F_MULT, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 32'hFFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_decoder_muldiv.md
Name: alu_decoder_muldiv

Overview:
- Next-generation ALU control block for the MIPS-32 datapath.
- Decodes ALUOp/Funct into a widened 4-bit ALU control code, covering the full R-type logical and compare set.
- Adds a parametrised iterative multiply/divide engine with HI/LO registers, covering MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall when a HI/LO-class instruction arrives while the engine is busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be even and ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decoded instruction present this cycle.
- ALUOp  in  2  main-decoder ALU class.
- Funct  in  6  instruction funct field.
- src_a  in  WIDTH  rs operand.
- src_b  in  WIDTH  rt operand.
- ALUControl  out  4  ALU operation code (combinational).
- illegal_funct  out  1  ALUOp=10 with an unmapped Funct (combinational).
- hilo_rd  out  1  MFHI/MFLO selects hilo_rdata for writeback (combinational).
- hilo_rdata  out  WIDTH  HI or LO per Funct (combinational).
- stall  out  1  hold the PC and pipeline this cycle (combinational).
- busy  out  1  engine iterating (registered).
- done  out  1  one-cycle pulse when HI/LO are updated (registered).

Behaviour:
- ALUOp decode:
  - 00 → 0010 (add).
  - 01 → 0110 (sub).
  - 11 → 0001 (or).
  - 10 → decode by Funct, table below.
- ALUOp=10 Funct table:
  - 100000/100001 → 0010.
  - 100010/100011 → 0110.
  - 100100 → 0000.
  - 100101 → 0001.
  - 100110 → 0011.
  - 100111 → 1100.
  - 101010 → 0111.
  - 101011 → 1000.
  - Muldiv-class funct codes (011000–011011, 010000–010011) → 0010, illegal_funct=0.
  - Any other Funct → 0010, illegal_funct=1.
- The decode path is fully combinational: no latches, every output is assigned on every path.
- FSM states: IDLE, ITER, FIXUP.
  - IDLE: on instr_valid & ALUOp=10 & Funct∈{MULT,MULTU,DIV,DIVU}, latch |src_a|, |src_b|, the signs, the op and the signedness. Unsigned ops latch raw values. Then go to ITER with count=0 and busy←1.
  - ITER: one radix-2 step per cycle. Multiply uses shift-add into a 2·WIDTH accumulator. Divide uses restoring shift-subtract. count increments each cycle; go to FIXUP after WIDTH steps.
  - FIXUP: apply sign correction and write HI/LO. Signed MULT negates the product if the signs differ. Signed DIV gives quotient sign a^b and remainder sign a. Then busy←0, done←1 for one cycle, and return to IDLE.
- Latency: start accepted at edge k; HI/LO and done are valid after edge k+WIDTH+1. busy is high from after edge k through edge k+WIDTH+1.
- Divide by zero: LO={WIDTH{1}}, HI=src_a, with normal latency.
- Signed divide of most-negative by −1: LO=most-negative, HI=0.
- MTHI/MTLO in IDLE: write HI/LO at the next edge; no done pulse.
- MFHI/MFLO: hilo_rd=1; hilo_rdata is the current HI/LO.
- stall = instr_valid & ALUOp=10 & muldiv-class Funct & (busy | state≠IDLE).
  - A muldiv instruction arriving while busy is not accepted; it must be re-presented.
  - In the done cycle the engine is IDLE, so MFLO reads the fresh value.
- rst asserted at any time, including mid-iteration:
  - State→IDLE.
  - HI, LO, count, busy, done → 0.
  - The in-flight operation is discarded and no done pulse is issued.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: during a multiply ITER, when the remaining multiplier bits are all zero, go directly to FIXUP. Minimum latency is 2 edges (zero multiplier). Division is unaffected.
- Undefined: multiply latency is fixed at WIDTH+1 edges regardless of data.

Decomposition:
- Package alu_pkg holds:
  - ALU control localparams (ALU_ADD=0010, ALU_SUB=0110, ALU_AND=0000, ALU_OR=0001, ALU_XOR=0011, ALU_NOR=1100, ALU_SLT=0111, ALU_SLTU=1000).
  - Funct code constants.
  - ALUOp codes.
  - The muldiv FSM state enum.
- Sub-module alu_ctrl_decode: purely combinational; produces ALUControl, illegal_funct and the muldiv-class/op flags.
- The top level contains the FSM, datapath and HI/LO registers.

Test Plan:
- R-type decode: ALUOp=10, Funct=100111 → ALUControl=1100, illegal_funct=0. Funct=111111 → ALUControl=0010, illegal_funct=1. ALUOp=01 → 0110.
- MULT: src_a=7, src_b=0xFFFFFFFD → after 33 edges LO=0xFFFFFFEB, HI=0xFFFFFFFF, one-cycle done, busy=1 for 33 cycles.
- DIVU 100/7 → LO=14, HI=2. DIV 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 5/0 → LO=0xFFFFFFFF, HI=5.
- Hazard: issue MULTU 3×4, then MFLO next cycle → stall=1 until done. In the done cycle stall=0, hilo_rdata=12. A second MULT while busy → stall=1, not accepted.
- Reset: assert rst asynchronously at iteration 10 of a DIV → busy, done, HI, LO go to 0 immediately. No done pulse follows. A new MULT afterwards completes normally.
- With MULDIV_EARLY_TERM_EN: MULTU 0x12345678×1 → done after 2 edges, LO=0x12345678, HI=0. Without the macro → 33 edges.
